ccd_sdram_packer: RTL and testbench

//  Write-side counterpart of the display-path SDRAM pixel decode. Takes the 10-bit RGB CCD

---
 rtl/ccd_sdram_packer.sv | 146 ++++++++++++++
 tb/tb_ccd_sdram_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_sdram_packer.sv
// Packs 10-bit RGB CCD pixels into the two-word SDRAM layout and streams them out
// through a small first-word-fall-through FIFO, one addressed write per pixel.
module ccd_sdram_packer #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned FRAME_PIXELS = 480000,
  parameter int unsigned ADDR_W       = 23,
  parameter int unsigned BASE_ADDR    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_frame_start,
  input  logic              i_pix_valid,
  input  logic [9:0]        i_red,
  input  logic [9:0]        i_green,
  input  logic [9:0]        i_blue,
  input  logic              i_pause,
  input  logic              i_wr_ready,
  output logic              o_wr_valid,
  output logic [15:0]       o_wr_data_1,
  output logic [15:0]       o_wr_data_2,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic              o_busy
);

  localparam int unsigned       PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned       CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FRAME_PIXELS);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [29:0]       mem_q [FIFO_DEPTH];
  logic [29:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d, done_q, done_d;
  logic              empty, full, busy, abort, in_ev, pop, push;
  logic [29:0]       head;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
            (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    busy  = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
    abort = i_frame_start && busy;
    // A pixel arriving with an abort is the first pixel of the restarted frame.
    in_ev = ((state_q == S_CAPTURE) || abort) && i_pix_valid && !i_pause;
    pop   = !empty && i_wr_ready && !abort;
    push  = in_ev && (abort || !full || pop);
    head  = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      addr_d   = BASE;
      ovf_d    = 1'b0;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
      addr_d   = addr_q + ADDR_W'(1);
    end

    if (push) begin
      mem_d[wr_ptr_d[PTR_W-1:0]] = {i_green[9:5], i_blue, i_green[4:0], i_red};
      wr_ptr_d = wr_ptr_d + (PTR_W + 1)'(1);
    end

    // Dropped pixels still count so the frame length stays exact.
    if (in_ev) begin
      cnt_d = cnt_d + CNT_W'(1);
      if (!push) ovf_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (i_frame_start) begin
          ovf_d  = 1'b0;
          cnt_d  = '0;
          addr_d = BASE;
        end
        if (!i_enable)          state_d = S_IDLE;
        else if (i_frame_start) state_d = S_CAPTURE;
      end
      S_CAPTURE, S_DRAIN: begin
        if (in_ev && (cnt_d == LAST)) begin
          state_d = S_DRAIN;
        end else if (abort) begin
          state_d = S_CAPTURE;
        end else if ((state_q == S_DRAIN) && (rd_ptr_d == wr_ptr_d)) begin
          done_d  = 1'b1;
          state_d = i_enable ? S_ARMED : S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign o_wr_valid   = !empty;
  assign o_wr_data_1  = {1'b0, head[29:15]};
  assign o_wr_data_2  = {1'b0, head[14:0]};
  assign o_wr_addr    = addr_q;
  assign o_frame_done = done_q;
  assign o_overflow   = ovf_q;
  assign o_busy       = busy;

endmodule

// File: tb/tb_ccd_sdram_packer.sv
// Randomised and directed bench for ccd_sdram_packer against a queue-based frame model.
module tb_ccd_sdram_packer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned FP    = 24;
  localparam int unsigned AW    = 23;
  localparam int unsigned BASE  = 5;

  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DRN = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, fs = 1'b0, pv = 1'b0, pause = 1'b0, rdy = 1'b0;
  logic [9:0] r = '0, g = '0, b = '0;

  logic          wv, done, ovf, busy;
  logic [15:0]   d1, d2;
  logic [AW-1:0] waddr;

  int n_vec = 0, n_err = 0, done_seen = 0, pops = 0;
  int d0 = 0, p0 = 0;

  int          m_mode = M_IDLE, m_cnt = 0, m_addr = BASE;
  bit          m_ovf = 1'b0, m_done = 1'b0;
  bit          m_abort, m_ev, m_pop;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  ccd_sdram_packer #(
    .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FP), .ADDR_W(AW), .BASE_ADDR(BASE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_frame_start(fs),
    .i_pix_valid(pv), .i_red(r), .i_green(g), .i_blue(b), .i_pause(pause),
    .i_wr_ready(rdy), .o_wr_valid(wv), .o_wr_data_1(d1), .o_wr_data_2(d2),
    .o_wr_addr(waddr), .o_frame_done(done), .o_overflow(ovf), .o_busy(busy)
  );

  function automatic logic [31:0] pk(input logic [9:0] rr, input logic [9:0] gg,
                                     input logic [9:0] bb);
    return {1'b0, gg[9:5], bb, 1'b0, gg[4:0], rr};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: compare outputs of the previous edge, then advance on this cycle's inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(wv), 0);
      chk("rst_addr", 32'(waddr), BASE);
      chk("rst_done", 32'(done), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_busy", 32'(busy), 0);
      m_mode = M_IDLE; m_q.delete(); m_cnt = 0; m_addr = BASE; m_ovf = 0; m_done = 0;
    end else begin
      chk("valid", 32'(wv), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("data1", 32'(d1), 32'(m_q[0][31:16]));
        chk("data2", 32'(d2), 32'(m_q[0][15:0]));
      end
      chk("addr", 32'(waddr), 32'(m_addr % (1 << AW)));
      chk("done", 32'(done), 32'(m_done));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(m_mode == M_CAP || m_mode == M_DRN));
      if (done) done_seen++;

      m_abort = fs && (m_mode == M_CAP || m_mode == M_DRN);
      m_ev    = (m_mode == M_CAP || m_abort) && pv && !pause;
      m_pop   = (m_q.size() != 0) && rdy && !m_abort;
      m_done  = 0;
      if (m_abort) begin
        m_q.delete(); m_cnt = 0; m_addr = BASE; m_ovf = 0;
      end
      if (m_pop) begin
        void'(m_q.pop_front());
        m_addr++;
        pops++;
      end
      if (m_ev) begin
        m_cnt++;
        if (m_q.size() < DEPTH) m_q.push_back(pk(r, g, b));
        else m_ovf = 1;
      end
      case (m_mode)
        M_IDLE: if (en) m_mode = M_ARMED;
        M_ARMED: begin
          if (fs) begin m_ovf = 0; m_cnt = 0; m_addr = BASE; end
          if (!en) m_mode = M_IDLE;
          else if (fs) m_mode = M_CAP;
        end
        default: begin
          if (m_abort) m_mode = M_CAP;
          if (m_ev && m_cnt == FP) m_mode = M_DRN;
          else if (m_mode == M_DRN && m_q.size() == 0) begin
            m_done = 1;
            m_mode = en ? M_ARMED : M_IDLE;
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_pix();
    r = 10'($urandom); g = 10'($urandom); b = 10'($urandom); pv = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Full frame with packing literal on the first pixel.
    en = 1'b1; step();
    fs = 1'b1; step(); fs = 1'b0;
    chk("cap_busy", 32'(busy), 1);
    d0 = done_seen; p0 = pops;
    rdy = 1'b1; r = 10'h3FF; g = 10'h2AA; b = 10'h155; pv = 1'b1; step(); pv = 1'b0;
    chk("pack_valid", 32'(wv), 1);
    chk("pack_w1", 32'(d1), 32'h5555);
    chk("pack_w2", 32'(d2), 32'h2BFF);
    chk("pack_addr", 32'(waddr), BASE);
    for (int i = 0; i < FP - 1; i++) begin rnd_pix(); step(); end
    pv = 1'b0;
    repeat (4) step();
    chk("f1_done_once", 32'(done_seen - d0), 1);
    chk("f1_pops", 32'(pops - p0), FP);
    chk("f1_rearmed", 32'(busy), 0);

    // Overflow: 20 pixels into a stalled 16-deep FIFO.
    d0 = done_seen; p0 = pops;
    fs = 1'b1; step(); fs = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin r = '0; g = 10'h3FF; b = '0; pv = 1'b1; end
      else rnd_pix();
      step();
    end
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_head", {d1, d2}, 32'h7C007C00);
    chk("ovf_nopop", 32'(pops - p0), 0);
    for (int i = 0; i < 4; i++) begin rnd_pix(); step(); end
    pv = 1'b0;
    chk("ovf_drain_busy", 32'(busy), 1);
    rdy = 1'b1;
    repeat (18) step();
    chk("ovf_pops", 32'(pops - p0), 16);
    chk("ovf_done", 32'(done_seen - d0), 1);
    chk("ovf_sticky", 32'(ovf), 1);

    // Abort mid-frame.
    d0 = done_seen;
    fs = 1'b1; step(); fs = 1'b0;
    chk("arm_ovf_clr", 32'(ovf), 0);
    for (int i = 0; i < 2; i++) begin rnd_pix(); step(); end
    pv = 1'b0; step();
    chk("ab_addr", 32'(waddr), BASE + 2);
    rdy = 1'b0;
    for (int i = 0; i < 17; i++) begin rnd_pix(); step(); end
    pv = 1'b0;
    chk("ab_ovf", 32'(ovf), 1);
    fs = 1'b1; step(); fs = 1'b0;
    chk("ab_flush", 32'(wv), 0);
    chk("ab_addr_rst", 32'(waddr), BASE);
    chk("ab_ovf_clr", 32'(ovf), 0);
    chk("ab_busy", 32'(busy), 1);
    chk("ab_no_done", 32'(done_seen - d0), 0);

    // Pause: pixels ignored, pops continue, frame length unaffected.
    for (int i = 0; i < 3; i++) begin rnd_pix(); step(); end
    rdy = 1'b1; pause = 1'b1;
    for (int i = 0; i < 5; i++) begin rnd_pix(); step(); end
    pause = 1'b0; pv = 1'b0;
    chk("pz_drained", 32'(wv), 0);
    chk("pz_addr", 32'(waddr), BASE + 3);
    for (int i = 0; i < FP - 4; i++) begin rnd_pix(); step(); end
    pv = 1'b0;
    repeat (3) step();
    chk("pz_not_done", 32'(done_seen - d0), 0);
    chk("pz_busy", 32'(busy), 1);
    rnd_pix(); step(); pv = 1'b0;
    repeat (4) step();
    chk("pz_done", 32'(done_seen - d0), 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 99) < 95);
      fs    = ($urandom_range(0, 59) == 0);
      pause = ($urandom_range(0, 9) == 0);
      rdy   = ($urandom_range(0, 99) < 60);
      rnd_pix();
      pv    = ($urandom_range(0, 99) < 70);
      step();
    end

    // Reset while draining with four entries.
    fs = 1'b0; pv = 1'b0; pause = 1'b0; en = 1'b1;
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    fs = 1'b1; step(); fs = 1'b0; rdy = 1'b1;
    for (int i = 0; i < FP - 4; i++) begin rnd_pix(); step(); end
    pv = 1'b0; step();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin rnd_pix(); step(); end
    pv = 1'b0;
    chk("rd_busy", 32'(busy), 1);
    chk("rd_valid", 32'(wv), 1);
    rst_n = 1'b0; #1;
    chk("rd_rst_valid", 32'(wv), 0);
    chk("rd_rst_busy", 32'(busy), 0);
    chk("rd_rst_addr", 32'(waddr), BASE);
    chk("rd_rst_done", 32'(done), 0);
    step(); rst_n = 1'b1; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
